cla_seq_ctrl: RTL

Sequencer for a wide multi-precision add built on one SLICE_W-bit carry-lookahead slice (per-bit p = a^b, g = a&b, sum = p^cin, cout = p&cin | g), reused over NUM_SLICES cycles.
- Accepts a start strobe with full-width operands and steps the slice from LSB to MSB chunk, one chunk per clock.
- Carries between chunks in a register and reports the result with a one-cycle done pulse.
- Sits between a requesting datapath and the shared slice logic, which is instantiated inside this block.

---
 rtl/cla_seq_ctrl_if.sv | 34 +++
 rtl/cla_seq_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl_if.sv
// Request/result bundle for the sequenced CLA adder.
// ovf exists only when CLA_SEQ_OVF_EN is defined.
interface cla_seq_ctrl_if #(
   parameter int OP_W = 16
);
   logic            start;
   logic [OP_W-1:0] a;
   logic [OP_W-1:0] b;
   logic            cin;
   logic            busy;
   logic            done;
   logic [OP_W-1:0] sum;
   logic            cout;
   logic            grp_p;
`ifdef CLA_SEQ_OVF_EN
   logic            ovf;
`endif

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, grp_p
`ifdef CLA_SEQ_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, grp_p
`ifdef CLA_SEQ_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/cla_seq_ctrl.sv
// Multi-precision adder: one SLICE_W-bit CLA slice reused per chunk.
// Optional signed-overflow output enabled by CLA_SEQ_OVF_EN.
module cla_seq_ctrl #(
   parameter int SLICE_W    = 4,
   parameter int NUM_SLICES = 4
) (
   input  logic          clk,
   input  logic          rst,
   cla_seq_ctrl_if.slave bus
);
   localparam int OP_W  = SLICE_W * NUM_SLICES;
   localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nx;

   logic [OP_W-1:0]    a_r, b_r, sum_r;
   logic [IDX_W-1:0]   idx;
   logic               carry, acc, cout_r, grp_r;
   logic               accept, last;
   logic [SLICE_W-1:0] sa, sb, sp, sg, ss;
   logic [SLICE_W:0]   sc;
   logic               pr;

   // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
   always_comb begin
      sa = a_r[idx*SLICE_W +: SLICE_W];
      sb = b_r[idx*SLICE_W +: SLICE_W];
      sp = sa ^ sb;
      sg = sa & sb;
      sc = '0;
      pr = 1'b0;
      sc[0] = carry;
      for (int i = 0; i < SLICE_W; i++) begin
         sc[i+1] = sg[i];
         pr = sp[i];
         for (int j = i - 1; j >= 0; j--) begin
            sc[i+1] = sc[i+1] | (pr & sg[j]);
            pr = pr & sp[j];
         end
         sc[i+1] = sc[i+1] | (pr & carry);
      end
      ss = sp ^ sc[SLICE_W-1:0];
   end

   assign last = (idx == IDX_W'(NUM_SLICES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            accept   = bus.start;
            state_nx = bus.start ? RUN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         acc    <= 1'b0;
         cout_r <= 1'b0;
         grp_r  <= 1'b0;
      end else if (accept) begin
         a_r    <= bus.a;
         b_r    <= bus.b;
         sum_r  <= '0;
         idx    <= '0;
         carry  <= bus.cin;
         acc    <= 1'b1;
         cout_r <= 1'b0;
         grp_r  <= 1'b0;
      end else if (state == RUN) begin
         sum_r[idx*SLICE_W +: SLICE_W] <= ss;
         carry <= sc[SLICE_W];
         acc   <= acc & (&sp);
         idx   <= last ? '0 : idx + 1'b1;
         if (last) begin
            cout_r <= sc[SLICE_W];
            grp_r  <= acc & (&sp);
         end
      end
   end

`ifdef CLA_SEQ_OVF_EN
   logic ovf_r;

   // Signed overflow: carry into MSB differs from carry out of MSB
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        ovf_r <= 1'b0;
      else if (accept)                ovf_r <= 1'b0;
      else if (state == RUN && last)  ovf_r <= sc[SLICE_W-1] ^ sc[SLICE_W];
   end

   assign bus.ovf = ovf_r;
`endif

   assign bus.busy  = (state == RUN);
   assign bus.done  = (state == DONE);
   assign bus.sum   = sum_r;
   assign bus.cout  = cout_r;
   assign bus.grp_p = grp_r;
endmodule
